// File: rtl/bp_tag_client_rx.sv
// bsg_tag client receiver: deserializes the tag lane into a width_p-bit payload,
// checks the frame length on commit, and offers the payload over valid/yumi.
module bp_tag_client_rx #(
    parameter int unsigned         width_p     = 8,
    parameter logic [width_p-1:0]  reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               tag_en_i,
    input  logic               tag_op_i,
    input  logic               tag_param_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               new_o,
    output logic               err_o,
    output logic               overrun_o
);

    localparam int unsigned cnt_w_lp = $clog2(width_p + 2);

    localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_sat_lp  = cnt_w_lp'(width_p + 1);

    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_shift    = 2'd1,
        e_overflow = 2'd2
    } state_e;

    state_e              state_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic [width_p-1:0]  sr_r;

    // Lane decode; a disabled lane is a NOP
    logic shift_c;
    logic commit_c;
    logic [width_p-1:0] sr_next_c;

    assign shift_c   = tag_en_i & tag_op_i;
    assign commit_c  = tag_en_i & ~tag_op_i & tag_param_i;
    assign sr_next_c = (width_p > 1) ? {tag_param_i, sr_r[width_p-1:1]}
                                     : width_p'(tag_param_i);

    // Frame FSM, bit counter, shift register and registered output pulses
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_idle;
            cnt_r     <= '0;
            sr_r      <= '0;
            data_o    <= reset_val_p;
            v_o       <= 1'b0;
            new_o     <= 1'b0;
            err_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            new_o     <= 1'b0;
            err_o     <= 1'b0;
            overrun_o <= 1'b0;

            // Consumption clears valid; a good commit below re-asserts it
            if (yumi_i && v_o) begin
                v_o <= 1'b0;
            end

            if (shift_c) begin
                sr_r <= sr_next_c;
            end

            case (state_r)
                e_idle: begin
                    if (shift_c) begin
                        cnt_r   <= cnt_w_lp'(1);
                        state_r <= (cnt_full_lp == cnt_w_lp'(0)) ? e_overflow : e_shift;
                    end else if (commit_c) begin
                        err_o <= 1'b1;
                    end
                end

                e_shift: begin
                    if (shift_c) begin
                        if (cnt_r == cnt_full_lp) begin
                            cnt_r   <= cnt_sat_lp;
                            state_r <= e_overflow;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end else if (commit_c) begin
                        if (cnt_r == cnt_full_lp) begin
                            data_o    <= sr_r;
                            v_o       <= 1'b1;
                            new_o     <= 1'b1;
                            overrun_o <= v_o & ~yumi_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                        cnt_r   <= '0;
                        state_r <= e_idle;
                    end
                end

                e_overflow: begin
                    if (commit_c) begin
                        err_o   <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= e_idle;
                    end
                end

                default: begin
                    cnt_r   <= '0;
                    state_r <= e_idle;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Consumer must not take a payload that is not there
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bp_tag_client_rx.sv
// Self-checking bench for bp_tag_client_rx (width_p=8, reset_val_p=0).
module tb_bp_tag_client_rx;

    logic       clk;
    logic       rst_n;
    logic       tag_en;
    logic       tag_op;
    logic       tag_param;
    logic [7:0] data_o;
    logic       v_o;
    logic       yumi;
    logic       new_o;
    logic       err_o;
    logic       overrun_o;

    bp_tag_client_rx #(.width_p(8), .reset_val_p(8'h00)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .tag_en_i   (tag_en),
        .tag_op_i   (tag_op),
        .tag_param_i(tag_param),
        .data_o     (data_o),
        .v_o        (v_o),
        .yumi_i     (yumi),
        .new_o      (new_o),
        .err_o      (err_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    logic       exp_v;
    logic [7:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One clock of lane activity, then check all outputs after the edge
    task automatic step(input logic en, input logic op, input logic param,
                        input logic y, input logic exp_err);
        exp_t e;
        @(negedge clk);
        tag_en = en; tag_op = op; tag_param = param; yumi = y;
        @(posedge clk);
        #1;
        if (new_o) begin
            if (sb_q.size() == 0) begin
                chk("new_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("data_at_new", data_o, e.data);
                chk("overrun_at_new", overrun_o, e.ovr);
            end
        end else begin
            chk("overrun_without_new", overrun_o, 0);
        end
        chk("err", err_o, exp_err);
        chk("v", v_o, exp_v);
        chk("data", data_o, exp_data);
    endtask

    task automatic shift_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, d[i % 8], 1'b0, 1'b0);
    endtask

    task automatic commit(input logic good, input logic [7:0] frame, input logic y);
        if (good) begin
            sb_q.push_back('{data: frame, ovr: exp_v & ~y});
            exp_data = frame;
            exp_v    = 1'b1;
        end else if (y) begin
            exp_v = 1'b0;
        end
        step(1'b1, 1'b0, 1'b1, y, ~good);
        if (good) chk("new_missing", 32'(sb_q.size()), 0);
    endtask

    task automatic frame_good(input logic [7:0] d, input logic y);
        shift_bits(d, 8);
        commit(1'b1, d, y);
    endtask

    task automatic consume;
        exp_v = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic nop;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] r;
        logic       y;
        tag_en = 0; tag_op = 0; tag_param = 0; yumi = 0;
        exp_v = 1'b0; exp_data = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("rst_data", data_o, 8'h00);
        chk("rst_v", v_o, 0);
        chk("rst_pulses", {new_o, err_o, overrun_o}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        nop();

        // Commit from IDLE is a framing error
        commit(1'b0, 8'h00, 1'b0);

        // Short frame rejected, then a good 8'hA5 frame
        shift_bits(8'hFF, 5);
        commit(1'b0, 8'h00, 1'b0);
        nop();
        frame_good(8'hA5, 1'b0);
        nop();
        consume();

        // Bits 1,0,1,1,0,0,0,0 give 8'h0D
        frame_good(8'h0D, 1'b0);
        nop();
        nop();
        consume();

        // Nine shifts overflow; commit errors and leaves data_o alone
        shift_bits(8'hC3, 9);
        commit(1'b0, 8'h00, 1'b0);

        // Disabled lane with op=1 must not count as a shift
        shift_bits(8'h0C, 4);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        commit(1'b1, 8'h3C, 1'b0);
        consume();

        // Overrun: 8'h11 pending, 8'h22 replaces it
        frame_good(8'h11, 1'b0);
        frame_good(8'h22, 1'b0);
        consume();

        // Commit together with yumi: no overrun, v_o stays high
        frame_good(8'h22, 1'b0);
        frame_good(8'h33, 1'b1);
        nop();

        // Failed commit with yumi still consumes, data_o untouched
        shift_bits(8'h07, 3);
        commit(1'b0, 8'h00, 1'b1);

        // Reset mid-frame with a payload pending
        frame_good(8'h77, 1'b0);
        shift_bits(8'hFF, 4);
        @(negedge clk);
        tag_en = 0; tag_op = 0; tag_param = 0; yumi = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", data_o, 8'h00);
        chk("midrst_v", v_o, 0);
        chk("midrst_pulses", {new_o, err_o, overrun_o}, 3'b000);
        exp_v = 1'b0; exp_data = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        frame_good(8'h5A, 1'b0);
        consume();

        // Random good frames with random consumption
        for (int k = 0; k < 20; k++) begin
            r = 8'($urandom_range(0, 255));
            y = exp_v & 1'($urandom_range(0, 1));
            frame_good(r, y);
            if ($urandom_range(0, 2) == 0) consume();
        end
        nop();

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
